// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and
// elaboration-time width helpers.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2,
        ST_IDLE    = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Clearable up-counter with a terminal-count strobe; returns to zero on the
// terminal edge so it never wraps past LIMIT-1.
module rst_seq_cnt #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] cnt;

    // tc is only meaningful on an edge where the count actually advances
    assign tc = en && !clr && (cnt == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domain resets low, then releases them one by one
// in ascending order and pulses rst_done once the last domain is out of reset.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   rst_done,
    output logic                   busy,
    output state_t                 state_dbg
);

    localparam int CW = clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int IW = clog2(NUM_DOMAINS) + 1;

    state_t                 state, state_nxt;
    logic [IW-1:0]          idx, idx_nxt;
    logic [NUM_DOMAINS-1:0] rst_out_nxt;
    logic                   done_nxt, busy_nxt;
    logic                   hold_tc, gap_tc;
    logic                   all_released;

    assign all_released = (idx == IW'(NUM_DOMAINS));
    assign state_dbg    = state;

    rst_seq_cnt #(.WIDTH(CW), .LIMIT(HOLD_CYCLES)) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sw_rst_req || (state != ST_HOLD)),
        .en    (state == ST_HOLD),
        .tc    (hold_tc)
    );

    rst_seq_cnt #(.WIDTH(CW), .LIMIT(GAP_CYCLES)) u_gap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sw_rst_req || (state != ST_RELEASE) || all_released),
        .en    ((state == ST_RELEASE) && !all_released),
        .tc    (gap_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HOLD;
            idx      <= '0;
            rst_out  <= '0;
            rst_done <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            rst_out  <= rst_out_nxt;
            rst_done <= done_nxt;
            busy     <= busy_nxt;
        end
    end

    // Outputs are computed one edge ahead and registered, so they never glitch.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        rst_out_nxt = rst_out;
        done_nxt    = 1'b0;
        busy_nxt    = 1'b1;
        unique case (state)
            ST_HOLD: begin
                rst_out_nxt = '0;
                if (hold_tc) begin
                    state_nxt = ST_RELEASE;
                    idx_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                if (all_released) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else if (gap_tc) begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx == IW'(i)) rst_out_nxt[i] = 1'b1;
                    end
                    idx_nxt = idx + IW'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
            ST_IDLE: begin
                busy_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_HOLD;
            end
        endcase
        // A soft request from any state restarts the whole sequence.
        if (sw_rst_req) begin
            state_nxt   = ST_HOLD;
            idx_nxt     = '0;
            rst_out_nxt = '0;
            done_nxt    = 1'b0;
            busy_nxt    = 1'b1;
        end
    end

endmodule
